// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the addsub scheduler
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;
  localparam int W_DEF = 16;
  localparam logic [4:0] AU_WIDTH_CODE = 5'd16;
endpackage

// File: rtl/addsub_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, last grant held by the parent
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);
  always_comb o_grant = !i_enable ? 2'b00 : (&i_valid) ? (i_last_grant ? 2'b01 : 2'b10) : i_valid;
endmodule

// File: rtl/addsub_sched.sv
// addsub_sched: shares one add/sub datapath between two requesters
module addsub_sched
  import addsub_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sgn,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sgn,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  output logic         au_sgn,
  output logic [4:0]   au_width,
  input  logic [W-1:0] au_ans,
  input  logic         au_neg,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_ans,
  output logic         rsp_neg,
  output logic         busy
);
  localparam int CW = $clog2(SETTLE + 1) + 1;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_last, r_id;
  logic [1:0] w_grant;
  logic w_hs, w_cap, w_rsp_hs;
  rr_arb2 u_arb (
    .i_valid     ({req1_valid, req0_valid}),
    .i_last_grant(r_last),
    .i_enable    (r_state == IDLE),
    .o_grant     (w_grant)
  );
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign w_hs = |w_grant;
  assign w_cap = (r_state == EXEC) && (r_cnt == CW'(SETTLE));
  assign w_rsp_hs = (r_state == DONE) && rsp_valid && rsp_ready;
  assign au_width = 5'(W);
  assign busy = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_hs ? EXEC : IDLE) :
             r_state == EXEC ? (w_cap ? DONE : EXEC) :
             (w_rsp_hs ? IDLE : DONE);
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // au_* only load on a grant, so the datapath inputs stay quiet outside EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      au_a <= '0;
      au_b <= '0;
      au_sgn <= OP_ADD;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_ans <= '0;
      rsp_neg <= 1'b0;
      r_last <= 1'b1;
      r_id <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_hs) begin
        au_a <= w_grant[1] ? req1_a : req0_a;
        au_b <= w_grant[1] ? req1_b : req0_b;
        au_sgn <= w_grant[1] ? req1_sgn : req0_sgn;
        r_id <= w_grant[1];
        r_last <= w_grant[1];
        r_cnt <= '0;
      end else if (r_state == EXEC) r_cnt <= r_cnt + 1'b1;
      if (w_cap) begin
        rsp_ans <= au_ans;
        rsp_neg <= au_neg;
        rsp_id <= r_id;
        rsp_valid <= 1'b1;
      end else if (w_rsp_hs) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_sched.sv
// tb_addsub_sched: table-driven scoreboard bench for addsub_sched
module tb_addsub_sched;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req0_valid, req0_ready, req0_sgn, req1_valid, req1_ready, req1_sgn;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, au_a, au_b, au_ans, rsp_ans;
  logic au_sgn, au_neg, rsp_valid, rsp_ready, rsp_id, rsp_neg, busy;
  logic [4:0] au_width;
  logic b_valid, b_ready, b_sgn, b_r1_ready, b_au_sgn, b_au_neg, b_rsp_valid, b_rsp_id, b_rsp_neg, b_busy;
  logic [15:0] b_a, b_b, b_au_a, b_au_b, b_au_ans, b_rsp_ans;
  logic [4:0] b_au_width;

  function automatic logic [16:0] dp(input logic [15:0] a, input logic [15:0] b, input logic s);
    if (s) return {1'b0, a + b};
    else if (a < b) return {1'b1, b - a};
    else return {1'b0, a - b};
  endfunction
  assign {au_neg, au_ans} = dp(au_a, au_b, au_sgn);
  assign {b_au_neg, b_au_ans} = dp(b_au_a, b_au_b, b_au_sgn);

  addsub_sched #(.W(16), .SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sgn(req0_sgn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sgn(req1_sgn),
    .au_a(au_a), .au_b(au_b), .au_sgn(au_sgn), .au_width(au_width), .au_ans(au_ans), .au_neg(au_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ans(rsp_ans), .rsp_neg(rsp_neg),
    .busy(busy)
  );
  addsub_sched #(.W(16), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(b_valid), .req0_ready(b_ready), .req0_a(b_a), .req0_b(b_b), .req0_sgn(b_sgn),
    .req1_valid(1'b0), .req1_ready(b_r1_ready), .req1_a(16'd0), .req1_b(16'd0), .req1_sgn(1'b0),
    .au_a(b_au_a), .au_b(b_au_b), .au_sgn(b_au_sgn), .au_width(b_au_width), .au_ans(b_au_ans), .au_neg(b_au_neg),
    .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_id(b_rsp_id), .rsp_ans(b_rsp_ans), .rsp_neg(b_rsp_neg),
    .busy(b_busy)
  );

  typedef struct { logic id; logic [15:0] a; logic [15:0] b; logic sgn; logic [15:0] ans; logic neg; } vec_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic sgn; } op_t;
  typedef struct { logic id; logic [15:0] ans; logic neg; } exp_t;
  vec_t tab[13];
  op_t q0[$], q1[$];
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  bit acc0 = 0, acc1 = 0;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, got, exp, $time);
    end
  endtask

  task automatic issue(input int i);
    op_t o;
    exp_t e;
    o = '{tab[i].a, tab[i].b, tab[i].sgn};
    e = '{tab[i].id, tab[i].ans, tab[i].neg};
    if (tab[i].id) q1.push_back(o); else q0.push_back(o);
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = sb.size() == 0 && q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid && !busy;
    end
    if (!done) begin
      chk("drain_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic chk_reset();
    chk("rst_au_a", au_a, 0);
    chk("rst_au_b", au_b, 0);
    chk("rst_au_sgn", au_sgn, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_ans", rsp_ans, 0);
    chk("rst_rsp_neg", rsp_neg, 0);
    chk("rst_busy", busy, 0);
  endtask

  always @(posedge clk) cyc++;

  initial begin
    op_t o;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sgn = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin req0_valid = 0; q0.delete(); acc0 = 0; end
      else if (!req0_valid || acc0) begin
        acc0 = 0;
        if (q0.size() > 0) begin
          o = q0.pop_front();
          req0_a = o.a; req0_b = o.b; req0_sgn = o.sgn; req0_valid = 1;
        end else req0_valid = 0;
      end
    end
  end
  initial begin
    op_t o;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sgn = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin req1_valid = 0; q1.delete(); acc1 = 0; end
      else if (!req1_valid || acc1) begin
        acc1 = 0;
        if (q1.size() > 0) begin
          o = q1.pop_front();
          req1_a = o.a; req1_b = o.b; req1_sgn = o.sgn; req1_valid = 1;
        end else req1_valid = 1'b0;
      end
    end
  end

  // ready must only go to a valid requester, one at a time, and only while idle
  always @(negedge clk) if (!rst) begin
    exp_t e;
    if (req0_valid && req0_ready) acc0 = 1;
    if (req1_valid && req1_ready) acc1 = 1;
    chk("ready_rule", !((req0_ready && (busy || !req0_valid)) || (req1_ready && (busy || !req1_valid)) ||
        (req0_ready && req1_ready)), 1);
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_ans", rsp_ans, e.ans);
        chk("rsp_neg", rsp_neg, e.neg);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, m, nb;
    logic [15:0] s_ans;
    logic s_id, s_neg;
    tab[0]  = '{0, 16'd5560, 16'd8101, 1, 16'd13661, 0};
    tab[1]  = '{0, 16'd1560, 16'd100, 0, 16'd1460, 0};
    tab[2]  = '{1, 16'd1260, 16'd2101, 0, 16'd841, 1};
    tab[3]  = '{0, 16'd100, 16'd200, 1, 16'd300, 0};
    tab[4]  = '{1, 16'd1000, 16'd1, 0, 16'd999, 0};
    tab[5]  = '{0, 16'd7, 16'd9, 0, 16'd2, 1};
    tab[6]  = '{1, 16'd0, 16'd0, 0, 16'd0, 0};
    tab[7]  = '{0, 16'd65535, 16'd1, 1, 16'd0, 0};
    tab[8]  = '{1, 16'd40000, 16'd30000, 1, 16'd4464, 0};
    tab[9]  = '{0, 16'd300, 16'd1000, 0, 16'd700, 1};
    tab[10] = '{1, 16'd5, 16'd5, 1, 16'd10, 0};
    tab[11] = '{0, 16'd9, 16'd4, 0, 16'd5, 0};
    tab[12] = '{1, 16'd2, 16'd3, 0, 16'd1, 1};
    rsp_ready = 1; b_valid = 0; b_a = 0; b_b = 0; b_sgn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    chk("au_width", au_width, 16);
    @(posedge clk); #2 rst = 0;

    // single op: latency, settle hold, busy length
    issue(0);
    k = -1;
    for (int i = 0; i < 20 && k < 0; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) k = cyc;
    end
    chk("accept_seen", k >= 0, 1);
    m = -1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      chk("hold_au_a", au_a, 5560);
      chk("hold_au_b", au_b, 8101);
      if (rsp_valid && m < 0) m = cyc;
    end
    chk("latency", m - k, 3);
    chk("busy_cycles", nb, 3);
    drain(20);

    // contention from reset: req0 wins first
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    issue(1); issue(2);
    drain(40);

    // continuous contention alternates grants
    for (int i = 3; i <= 8; i++) issue(i);
    drain(100);

    // back-pressure in DONE
    @(posedge clk); #1 rsp_ready = 0;
    issue(9); issue(10);
    m = 0;
    for (int i = 0; i < 20 && !m; i++) begin
      @(negedge clk);
      m = rsp_valid;
    end
    chk("bp_rsp_valid_seen", m, 1);
    s_ans = rsp_ans; s_id = rsp_id; s_neg = rsp_neg;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_ans", rsp_ans, s_ans);
      chk("bp_id", rsp_id, s_id);
      chk("bp_neg", rsp_neg, s_neg);
      chk("bp_no_ready", req0_ready | req1_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle", busy, 0);
    chk("bp_next_ready", req1_ready, 1);
    drain(40);

    // reset mid-EXEC discards the op and restores req0 priority
    q0.push_back('{16'd61560, 16'd60101, 1'b1});
    m = 0;
    for (int i = 0; i < 20 && !m; i++) begin
      @(negedge clk);
      m = busy;
    end
    chk("abort_exec_seen", m, 1);
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk_reset();
    issue(11); issue(12);
    drain(40);

    // SETTLE=3 instance: longer hold, wrapped add forwarded unmodified
    @(posedge clk); #1 b_a = 16'd61560; b_b = 16'd60101; b_sgn = 1; b_valid = 1;
    k = -1;
    for (int i = 0; i < 20 && k < 0; i++) begin
      @(negedge clk);
      if (b_ready) k = cyc;
    end
    chk("s3_accept_seen", k >= 0, 1);
    @(posedge clk); #1 b_valid = 0;
    m = -1; nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!b_busy) break;
      nb++;
      chk("s3_hold_au_a", b_au_a, 61560);
      if (b_rsp_valid && m < 0) begin
        m = cyc;
        chk("s3_ans", b_rsp_ans, 56125);
        chk("s3_neg", b_rsp_neg, 0);
        chk("s3_id", b_rsp_id, 0);
      end
    end
    chk("s3_latency", m - k, 5);
    chk("s3_busy_cycles", nb, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
